// File: rtl/alu_4bit.sv
// alu_4bit: registered ALU with eight operations.
// The result, the carry/borrow/shifted-out bit and the zero flag are computed
// combinationally and loaded into registers on an enabled clock edge. An
// asynchronous active-low reset clears the result, the carry and the zero
// flag's operand without waiting for a clock.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] ALU_Out,
  output logic             CarryOut,
  output logic             Zero
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             cy;
  } alu_rsp_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  // Both adders are one bit wider than the operands. For subtraction the top
  // bit of the widened difference is set exactly when A < B, i.e. the borrow.
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  alu_rsp_t       nxt;

  assign sum  = {1'b0, A} + {1'b0, B};
  assign diff = {1'b0, A} - {1'b0, B};

  // Select the next result and its carry from the operation code.
  always_comb begin
    nxt = '0;
    unique case (ALU_Sel)
      OP_ADD: nxt = '{res: sum[WIDTH-1:0],  cy: sum[WIDTH]};
      OP_SUB: nxt = '{res: diff[WIDTH-1:0], cy: diff[WIDTH]};
      OP_AND: nxt = '{res: A & B, cy: 1'b0};
      OP_OR:  nxt = '{res: A | B, cy: 1'b0};
      OP_XOR: nxt = '{res: A ^ B, cy: 1'b0};
      OP_SHL: nxt = '{res: {A[WIDTH-2:0], 1'b0}, cy: A[WIDTH-1]};
      OP_SHR: nxt = '{res: {1'b0, A[WIDTH-1:1]}, cy: A[0]};
      OP_NOT: nxt = '{res: ~A, cy: 1'b0};
      default: nxt = '0;
    endcase
  end

  // Result registers: clear asynchronously, load only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_Out  <= '0;
      CarryOut <= 1'b0;
      Zero     <= 1'b1;
    end else if (en) begin
      ALU_Out  <= nxt.res;
      CarryOut <= nxt.cy;
      Zero     <= (nxt.res == '0);
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: scoreboard bench for alu_4bit. Expected results come from an
// integer reference model and are queued when stimulus is driven; they are
// popped and compared once the DUT has registered its output.
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] ALU_Sel;
  logic [3:0] ALU_Out;
  logic       CarryOut;
  logic       Zero;

  typedef struct packed {
    logic [3:0] out;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  alu_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .A(A), .B(B), .ALU_Sel(ALU_Sel),
    .ALU_Out(ALU_Out), .CarryOut(CarryOut), .Zero(Zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Integer reference model of the operation table.
  function automatic exp_t model(input int a, input int b, input int sel);
    int r;
    int c;
    r = 0;
    c = 0;
    case (sel)
      0: begin r = (a + b) % 16; c = (a + b > 15) ? 1 : 0; end
      1: begin r = (a - b + 16) % 16; c = (a < b) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin r = (a * 2) % 16; c = a / 8; end
      6: begin r = a / 2; c = a % 2; end
      default: r = 15 - a;
    endcase
    model.out = 4'(r);
    model.c   = (c != 0);
    model.z   = (r == 0);
  endfunction

  // Drive one enabled operation at the falling edge and queue its result.
  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    @(negedge clk);
    A = a; B = b; ALU_Sel = sel; en = 1'b1;
    sb.push_back(model(int'(a), int'(b), int'(sel)));
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; A = 4'hA; B = 4'h5; ALU_Sel = 3'b000;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_async: got %b/%b/%b want 0000/0/1", ALU_Out, CarryOut, Zero);
    end
    // Clock edges with en=1 must be ignored while reset is held.
    en = 1'b1; A = 4'hF; B = 4'h3; ALU_Sel = 3'b011;
    @(posedge clk); #1;
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_held: got %b/%b/%b want 0000/0/1", ALU_Out, CarryOut, Zero);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
  endtask

  task automatic test_sweep();
    for (int s = 0; s < 8; s++) begin
      drive(4'b1010, 4'b0101, 3'(s));
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
        miscompares++;
        $display("FAIL sweep_sel%0d: got %b/%b/%b want %b/%b/%b",
                 s, ALU_Out, CarryOut, Zero, e.out, e.c, e.z);
      end
    end
  endtask

  task automatic test_boundaries();
    drive(4'b1111, 4'b0001, 3'b000);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b0000, 1'b1, 1'b1} ||
        {ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
      miscompares++;
      $display("FAIL add_wrap: got %b/%b/%b want 0000/1/1", ALU_Out, CarryOut, Zero);
    end
    drive(4'b0011, 4'b0101, 3'b001);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b1110, 1'b1, 1'b0} ||
        {ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
      miscompares++;
      $display("FAIL sub_borrow: got %b/%b/%b want 1110/1/0", ALU_Out, CarryOut, Zero);
    end
  endtask

  task automatic test_hold();
    drive(4'b1010, 4'b0101, 3'b000);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b1111, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL hold_load: got %b/%b/%b want 1111/0/0", ALU_Out, CarryOut, Zero);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; A = 4'(i + 1); B = 4'(3 * i); ALU_Sel = 3'(i + 1);
      sb.push_back('{out: 4'b1111, c: 1'b0, z: 1'b0});
      #1;
      vectors++;
      if ({ALU_Out, CarryOut, Zero} !== {4'b1111, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL hold_comb%0d: got %b/%b/%b want 1111/0/0", i, ALU_Out, CarryOut, Zero);
      end
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
        miscompares++;
        $display("FAIL hold_edge%0d: got %b/%b/%b want %b/%b/%b",
                 i, ALU_Out, CarryOut, Zero, e.out, e.c, e.z);
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(4'b1100, 4'b0011, 3'b011);
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
      miscompares++;
      $display("FAIL midrst_load: got %b/%b/%b want %b/%b/%b",
               ALU_Out, CarryOut, Zero, e.out, e.c, e.z);
    end
    // Pending SHL of 1001 is discarded by the pulse; nothing is queued for it.
    @(negedge clk);
    A = 4'b1001; B = 4'b0000; ALU_Sel = 3'b101; en = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b0000, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL midrst_clear: got %b/%b/%b want 0000/0/1", ALU_Out, CarryOut, Zero);
    end
    #1 rst_n = 1'b1;
    sb.push_back(model(9, 0, 5));
    @(posedge clk); #1;
    e = sb.pop_front();
    vectors++;
    if ({ALU_Out, CarryOut, Zero} !== {4'b0010, 1'b1, 1'b0} ||
        {ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
      miscompares++;
      $display("FAIL midrst_reload: got %b/%b/%b want 0010/1/0", ALU_Out, CarryOut, Zero);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      @(posedge clk); #1;
      e = sb.pop_front();
      vectors++;
      if ({ALU_Out, CarryOut, Zero} !== {e.out, e.c, e.z}) begin
        miscompares++;
        $display("FAIL b2b_%0d: A=%b B=%b sel=%b got %b/%b/%b want %b/%b/%b",
                 i, A, B, ALU_Sel, ALU_Out, CarryOut, Zero, e.out, e.c, e.z);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_boundaries();
    test_hold();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand and result width; all requirements are stated for WIDTH=4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: load enable; result registers update only when en=1.
REQ-005 The block SHALL have port A, input, WIDTH bits: operand A, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits: operand B, unsigned.
REQ-007 The block SHALL have port ALU_Sel, input, 3 bits: operation select.
REQ-008 The block SHALL have port ALU_Out, output, WIDTH bits: registered result.
REQ-009 The block SHALL have port CarryOut, output, 1 bit: registered carry, borrow or shifted-out bit.
REQ-010 The block SHALL have port Zero, output, 1 bit: registered flag, 1 when the registered ALU_Out is all zeros.

Function
REQ-011 When ALU_Sel=000 (ADD), the block SHALL compute result=(A+B) mod 16 and carry=bit 4 of the 5-bit sum.
REQ-012 When ALU_Sel=001 (SUB), the block SHALL compute result=(A-B) mod 16 and carry=1 iff A<B (borrow).
REQ-013 When ALU_Sel=010 (AND), the block SHALL compute result=A&B with carry=0.
REQ-014 When ALU_Sel=011 (OR), the block SHALL compute result=A|B with carry=0.
REQ-015 When ALU_Sel=100 (XOR), the block SHALL compute result=A^B with carry=0.
REQ-016 When ALU_Sel=101 (SHL), the block SHALL compute result={A[2:0],0} with carry=A[3]; B is ignored.
REQ-017 When ALU_Sel=110 (SHR, logical), the block SHALL compute result={0,A[3:1]} with carry=A[0]; B is ignored.
REQ-018 When ALU_Sel=111 (NOT), the block SHALL compute result=~A with carry=0; B is ignored.
REQ-019 On each rising clk edge with en=1 and rst_n=1, the block SHALL load result into ALU_Out, carry into CarryOut, and (result==0) into Zero.
REQ-020 Latency SHALL be exactly one clock: inputs sampled at edge N appear on the outputs after edge N and hold until the next enabled edge.
REQ-021 With en=0, ALU_Out, CarryOut and Zero SHALL hold their previous values regardless of A, B or ALU_Sel changes.
REQ-022 Outputs SHALL NOT change combinationally with inputs; only clk edges or reset alter them.
REQ-023 All arithmetic SHALL wrap modulo 16 with no saturation; overflow is reported only through CarryOut.

Reset
REQ-024 When rst_n=0, the block SHALL immediately, without waiting for clk, force ALU_Out=0000, CarryOut=0 and Zero=1.
REQ-025 While rst_n=0, the block SHALL ignore clk edges and en.
REQ-026 After rst_n deasserts, the first rising clk edge with en=1 SHALL load a new result normally.
REQ-027 If rst_n asserts mid-operation, any pending result SHALL be discarded with no partial update.

Verification
REQ-028 A bench SHALL cover reset: drive rst_n=0 with no clk edge -> ALU_Out=0000, CarryOut=0, Zero=1.
REQ-029 A bench SHALL cover an opcode sweep with A=1010, B=0101, en=1, ALU_Sel 000..111, one clock each -> ALU_Out/CarryOut of 1111/0, 0101/0, 0000/0 (Zero=1), 1111/0, 1111/0, 0100/1, 0101/0, 0101/0.
REQ-030 A bench SHALL cover ADD wrap: A=1111, B=0001, ALU_Sel=000 -> ALU_Out=0000, CarryOut=1, Zero=1.
REQ-031 A bench SHALL cover SUB borrow: A=0011, B=0101, ALU_Sel=001 -> ALU_Out=1110, CarryOut=1, Zero=0.
REQ-032 A bench SHALL cover hold: load 1111 via ADD, then set en=0 and change A, B and ALU_Sel for 3 clocks -> outputs stay 1111/0/0.
REQ-033 A bench SHALL cover reset mid-operation: pulse rst_n low between clock edges while en=1 -> outputs clear at once, then reload on the first edge after release.
